// File: rtl/video_pattern_gen.sv
// Raster timing generator and test-pattern source with a valid/ready beat stream.
// One beat per raster position (blanking included); sync, DE and SOF flags ride in tuser.
module video_pattern_gen #(
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int V_ACTIVE   = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter int BPC        = 8,
    parameter bit HSYNC_POL  = 1'b1,
    parameter bit VSYNC_POL  = 1'b1,
    parameter int CHECK_LOG2 = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [3*BPC-1:0] solid_i,
    output logic             tvalid_o,
    input  logic             tready_i,
    output logic [3*BPC-1:0] tdata_o,
    output logic [3:0]       tuser_o,
    output logic [15:0]      frame_cnt_o
);

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters are widened so the ramp and checkerboard bit selects always exist.
    localparam int HW    = max_f(max_f($clog2(H_TOTAL), CHECK_LOG2 + 1), BPC);
    localparam int VW    = max_f($clog2(V_TOTAL), CHECK_LOG2 + 1);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = max_f($clog2(BAR_W), 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [3*BPC-1:0] pixel_f(
        input logic [HW-1:0]    h,
        input logic [VW-1:0]    v,
        input logic [1:0]       mode,
        input logic [3*BPC-1:0] solid,
        input logic [2:0]       bar
    );
        logic [BPC-1:0]   m;
        logic [BPC-1:0]   z;
        logic [3*BPC-1:0] px;
        m  = {BPC{1'b1}};
        z  = {BPC{1'b0}};
        px = {3*BPC{1'b0}};
        if ((h < H_ACT) && (v < V_ACT)) begin
            case (mode)
                2'd0: begin
                    case (bar)
                        3'd0:    px = {m, m, m};
                        3'd1:    px = {m, m, z};
                        3'd2:    px = {z, m, m};
                        3'd3:    px = {z, m, z};
                        3'd4:    px = {m, z, m};
                        3'd5:    px = {m, z, z};
                        3'd6:    px = {z, z, m};
                        default: px = {z, z, z};
                    endcase
                end
                2'd1:    px = {3{h[BPC-1:0]}};
                2'd2:    px = (h[CHECK_LOG2] ^ v[CHECK_LOG2]) ? {m, m, m} : {z, z, z};
                default: px = solid;
            endcase
        end else begin
            px = {3*BPC{1'b0}};
        end
        return px;
    endfunction

    function automatic logic [3:0] flags_f(input logic [HW-1:0] h, input logic [VW-1:0] v);
        logic [3:0] f;
        f[0] = (h == {HW{1'b0}}) && (v == {VW{1'b0}});
        f[1] = ((h >= HS_START) && (h < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        f[2] = ((v >= VS_START) && (v < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        f[3] = (h < H_ACT) && (v < V_ACT);
        return f;
    endfunction

    state_e           state_q, state_d;
    logic             tvalid_q, tvalid_d;
    logic [3*BPC-1:0] tdata_q, tdata_d;
    logic [3:0]       tuser_q, tuser_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [HW-1:0]    h_q, h_d;
    logic [VW-1:0]    v_q, v_d;
    logic [BW-1:0]    bar_cnt_q, bar_cnt_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [1:0]       mode_q, mode_d;
    logic [3*BPC-1:0] solid_q, solid_d;
    logic             start_s, adv_s, stop_s;

    // Next-state, raster advance and registered beat generation.
    always_comb begin
        state_d     = state_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        tuser_d     = tuser_q;
        frame_cnt_d = frame_cnt_q;
        h_d         = h_q;
        v_d         = v_q;
        bar_cnt_d   = bar_cnt_q;
        bar_idx_d   = bar_idx_q;
        mode_d      = mode_q;
        solid_d     = solid_q;
        start_s     = 1'b0;
        adv_s       = 1'b0;
        stop_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_s = en_i;
            end
            ST_RUN: begin
                if (tvalid_q && tready_i) begin
                    if ((h_q == H_LAST) && (v_q == V_LAST)) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        start_s     = en_i;
                        stop_s      = ~en_i;
                    end else begin
                        adv_s = 1'b1;
                    end
                end else begin
                    adv_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_s) begin
            state_d   = ST_RUN;
            tvalid_d  = 1'b1;
            h_d       = {HW{1'b0}};
            v_d       = {VW{1'b0}};
            bar_cnt_d = {BW{1'b0}};
            bar_idx_d = 3'd0;
            mode_d    = mode_i;
            solid_d   = solid_i;
        end else if (adv_s) begin
            if (h_q == H_LAST) begin
                h_d       = {HW{1'b0}};
                v_d       = v_q + VW'(1);
                bar_cnt_d = {BW{1'b0}};
                bar_idx_d = 3'd0;
            end else begin
                h_d = h_q + HW'(1);
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = {BW{1'b0}};
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + BW'(1);
                end
            end
        end else if (stop_s) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tdata_d  = {3*BPC{1'b0}};
            tuser_d  = 4'd0;
            h_d      = {HW{1'b0}};
            v_d      = {VW{1'b0}};
        end else begin
            state_d = state_d;
        end

        if (start_s || adv_s) begin
            tdata_d = pixel_f(h_d, v_d, mode_d, solid_d, bar_idx_d);
            tuser_d = flags_f(h_d, v_d);
        end else begin
            tuser_d = tuser_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            tvalid_q    <= 1'b0;
            tdata_q     <= {3*BPC{1'b0}};
            tuser_q     <= 4'd0;
            frame_cnt_q <= 16'd0;
            h_q         <= {HW{1'b0}};
            v_q         <= {VW{1'b0}};
            bar_cnt_q   <= {BW{1'b0}};
            bar_idx_q   <= 3'd0;
            mode_q      <= 2'd0;
            solid_q     <= {3*BPC{1'b0}};
        end else begin
            state_q     <= state_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            frame_cnt_q <= frame_cnt_d;
            h_q         <= h_d;
            v_q         <= v_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            mode_q      <= mode_d;
            solid_q     <= solid_d;
        end
    end

    assign tvalid_o    = tvalid_q;
    assign tdata_o     = tdata_q;
    assign tuser_o     = tuser_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: a small-raster instance checked every cycle against a
// position-based model, plus a default-geometry instance for the colour-bar edges.
module tb_video_pattern_gen;

    localparam int SHA = 16, SHF = 2, SHS = 2, SHB = 2;
    localparam int SVA = 4, SVF = 1, SVS = 1, SVB = 1;
    localparam int SCL = 2;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;
    localparam int NB  = SHT * SVT;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst, s_en, s_tready, s_tvalid;
    logic [1:0]  s_mode;
    logic [23:0] s_solid, s_tdata;
    logic [3:0]  s_tuser;
    logic [15:0] s_fcnt;

    logic        d_rst, d_en, d_tready, d_tvalid;
    logic [1:0]  d_mode;
    logic [23:0] d_solid, d_tdata;
    logic [3:0]  d_tuser;
    logic [15:0] d_fcnt;

    video_pattern_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .BPC(8), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CHECK_LOG2(SCL)
    ) u_small (
        .clk_i(clk), .rst_i(s_rst), .en_i(s_en), .mode_i(s_mode), .solid_i(s_solid),
        .tvalid_o(s_tvalid), .tready_i(s_tready), .tdata_o(s_tdata), .tuser_o(s_tuser),
        .frame_cnt_o(s_fcnt)
    );

    video_pattern_gen u_dflt (
        .clk_i(clk), .rst_i(d_rst), .en_i(d_en), .mode_i(d_mode), .solid_i(d_solid),
        .tvalid_o(d_tvalid), .tready_i(d_tready), .tdata_o(d_tdata), .tuser_o(d_tuser),
        .frame_cnt_o(d_fcnt)
    );

    int checks = 0;
    int errors = 0;

    // model of the small instance: what position is on the output and in which mode
    bit          m_run;
    int          m_h, m_v, m_mode, m_frames;
    logic [23:0] m_solid;

    int          n_beats = 0, n_sof = 0, n_de = 0, n_hs = 0, n_vs = 0;
    logic [23:0] sof_data = 24'h0;
    logic        stall = 1'b0;
    logic [27:0] prev_out = 28'h0;
    logic [27:0] log_a [NB];
    logic [27:0] log_b [NB];
    int          log_sel = 0, log_idx = 0;
    int          d_idx = 0;
    logic [27:0] d_cap [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int h, input int v, input int mode,
                                            input logic [23:0] solid);
        logic [7:0] r;
        if (!(h < SHA && v < SVA)) return 24'h0;
        case (mode)
            0:       return BARS[h / (SHA / 8)];
            1:       begin r = 8'(h % 256); return {r, r, r}; end
            2:       return ((((h >> SCL) ^ (v >> SCL)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
            default: return solid;
        endcase
    endfunction

    function automatic logic [3:0] exp_user(input int h, input int v);
        logic [3:0] u;
        u[0] = (h == 0) && (v == 0);
        u[1] = (h >= SHA + SHF) && (h < SHA + SHF + SHS);
        u[2] = (v >= SVA + SVF) && (v < SVA + SVF + SVS);
        u[3] = (h < SHA) && (v < SVA);
        return u;
    endfunction

    // observe the pending edge, predict it, clock it, then compare against the model
    task automatic tick();
        if (s_tvalid === 1'b1 && s_tready && !s_rst) begin
            n_beats++;
            if (s_tuser[0]) begin n_sof++; sof_data = s_tdata; log_idx = 0; end
            if (s_tuser[3]) n_de++;
            if (s_tuser[1]) n_hs++;
            if (s_tuser[2]) n_vs++;
            if (log_idx < NB) begin
                if (log_sel == 1) log_a[log_idx] = {s_tuser, s_tdata};
                if (log_sel == 2) log_b[log_idx] = {s_tuser, s_tdata};
            end
            log_idx++;
        end
        if (d_tvalid === 1'b1 && d_tready && !d_rst) begin
            if (d_tuser[0]) d_idx = 0;
            if (d_idx == 0)    d_cap[0] = {d_tuser, d_tdata};
            if (d_idx == 159)  d_cap[1] = {d_tuser, d_tdata};
            if (d_idx == 160)  d_cap[2] = {d_tuser, d_tdata};
            if (d_idx == 1279) d_cap[3] = {d_tuser, d_tdata};
            if (d_idx == 1280) d_cap[4] = {d_tuser, d_tdata};
            d_idx++;
        end
        stall    = (s_tvalid === 1'b1) && !s_tready && !s_rst;
        prev_out = {s_tuser, s_tdata};

        if (s_rst) begin
            m_run = 1'b0; m_h = 0; m_v = 0; m_mode = 0; m_solid = 24'h0; m_frames = 0;
        end else if (!m_run) begin
            if (s_en) begin
                m_run = 1'b1; m_h = 0; m_v = 0; m_mode = int'(s_mode); m_solid = s_solid;
            end
        end else if (s_tready) begin
            if (m_h == SHT - 1 && m_v == SVT - 1) begin
                m_frames = (m_frames + 1) % 65536;
                m_h = 0; m_v = 0;
                if (s_en) begin m_mode = int'(s_mode); m_solid = s_solid; end
                else m_run = 1'b0;
            end else begin
                m_h++;
                if (m_h == SHT) begin m_h = 0; m_v++; end
            end
        end

        @(posedge clk);
        @(negedge clk);

        chk("tvalid", 32'(s_tvalid), 32'(m_run));
        chk("frame_cnt", 32'(s_fcnt), 32'(m_frames));
        if (m_run) begin
            chk($sformatf("tdata h%0d v%0d", m_h, m_v), 32'(s_tdata), 32'(exp_pix(m_h, m_v, m_mode, m_solid)));
            chk($sformatf("tuser h%0d v%0d", m_h, m_v), 32'(s_tuser), 32'(exp_user(m_h, m_v)));
        end
        if (stall) chk("hold_stable", 32'({s_tuser, s_tdata}), 32'(prev_out));
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        while (s_tvalid === 1'b1 && k < lim) begin
            tick();
            k++;
        end
        chk("reached_idle", 32'(s_tvalid), 32'd0);
    endtask

    initial begin
        int diff, sof0, k;
        s_rst = 1'b1; s_en = 1'b0; s_mode = 2'd0; s_solid = 24'h0; s_tready = 1'b1;
        d_rst = 1'b1; d_en = 1'b0; d_mode = 2'd0; d_solid = 24'h0; d_tready = 1'b1;
        for (int i = 0; i < 5; i++) d_cap[i] = 28'hFFFFFFF;

        // reset and idle
        repeat (3) tick();
        s_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_tvalid", 32'(s_tvalid), 32'd0);
            chk("idle_tuser", 32'(s_tuser), 32'd0);
            chk("idle_fcnt", 32'(s_fcnt), 32'd0);
        end

        // one small frame from a single-cycle enable pulse
        log_sel = 1;
        s_en = 1'b1; s_mode = 2'd0;
        tick();
        s_en = 1'b0;
        wait_idle(400);
        chk("frame_beats", 32'(n_beats), 32'd154);
        chk("frame_sof", 32'(n_sof), 32'd1);
        chk("frame_de", 32'(n_de), 32'd64);
        chk("frame_hsync", 32'(n_hs), 32'd14);
        chk("frame_vsync", 32'(n_vs), 32'd22);
        chk("frame_cnt_1", 32'(s_fcnt), 32'd1);
        chk("beat_0_0", 32'(log_a[0]), 32'h9FFFFFF);
        chk("beat_2_0", 32'(log_a[2]), 32'h8FFFF00);
        chk("beat_18_0", 32'(log_a[18]), 32'h2000000);
        chk("beat_3_5", 32'(log_a[5 * SHT + 3]), 32'h4000000);

        // same frame under random backpressure
        log_sel = 2;
        s_en = 1'b1;
        tick();
        s_en = 1'b0;
        k = 0;
        while (s_tvalid === 1'b1 && k < 2000) begin
            s_tready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        s_tready = 1'b1;
        chk("bp_idle", 32'(s_tvalid), 32'd0);
        diff = 0;
        for (int i = 0; i < NB; i++) if (log_a[i] !== log_b[i]) diff++;
        chk("bp_sequence", 32'(diff), 32'd0);
        chk("frame_cnt_2", 32'(s_fcnt), 32'd2);
        log_sel = 0;

        // checkerboard and ramp frames
        s_en = 1'b1; s_mode = 2'd2; tick(); s_en = 1'b0; wait_idle(400);
        s_en = 1'b1; s_mode = 2'd1; tick(); s_en = 1'b0; wait_idle(400);

        // mode change mid-frame, then enable drop mid-frame
        s_rst = 1'b1; repeat (2) tick(); s_rst = 1'b0;
        sof0 = n_sof;
        s_mode = 2'd0; s_en = 1'b1;
        repeat (50) tick();
        chk("first_frame_bars", 32'(sof_data), 32'hFFFFFF);
        s_mode = 2'd3; s_solid = 24'h123456;
        k = 0;
        while (n_sof < sof0 + 2 && k < 400) begin tick(); k++; end
        chk("second_sof_seen", 32'(n_sof), 32'(sof0 + 2));
        chk("solid_next_frame", 32'(sof_data), 32'h123456);
        repeat (30) tick();
        s_en = 1'b0;
        wait_idle(400);
        chk("frame_cnt_two", 32'(s_fcnt), 32'd2);

        // reset in the middle of a frame
        s_mode = 2'd2; s_en = 1'b1; tick(); s_en = 1'b0;
        repeat (40) tick();
        s_rst = 1'b1; s_en = 1'b1; s_mode = 2'd1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_tvalid", 32'(s_tvalid), 32'd0);
            chk("rst_tdata", 32'(s_tdata), 32'd0);
            chk("rst_tuser", 32'(s_tuser), 32'd0);
            chk("rst_fcnt", 32'(s_fcnt), 32'd0);
        end
        s_rst = 1'b0;
        tick();
        chk("rst_first_user", 32'(s_tuser), 32'h9);
        chk("rst_first_data", 32'(s_tdata), 32'h000000);
        s_en = 1'b0;
        tick();
        chk("rst_ramp_h1", 32'(s_tdata), 32'h010101);
        wait_idle(400);
        chk("rst_frame_cnt", 32'(s_fcnt), 32'd1);

        // colour bars on the default geometry, line 0
        repeat (2) tick();
        d_rst = 1'b0; d_en = 1'b1;
        tick();
        d_en = 1'b0;
        repeat (1290) tick();
        chk("bars_h0", 32'(d_cap[0]), 32'h9FFFFFF);
        chk("bars_h159", 32'(d_cap[1]), 32'h8FFFFFF);
        chk("bars_h160", 32'(d_cap[2]), 32'h8FFFF00);
        chk("bars_h1279", 32'(d_cap[3]), 32'h8000000);
        chk("bars_h1280", 32'(d_cap[4]), 32'h0000000);
        d_rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
